bram_stream_ctrl: RTL and testbench
===================================

BRAM_STREAM_CTRL -- requirements
Module: bram_stream_ctrl

Interface
REQ-001 Parameter AW, default 6, byte-address width of the attached bram_bank; word depth D = 2^(AW-2).
REQ-002 CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 RESETn  input  1  asynchronous, active-low reset.
REQ-004 START  input  1  one-cycle command strobe, sampled only when BUSY=0.
REQ-005 MODE  input  1  0 = read-stream, 1 = fill; sampled with START.
REQ-006 BASE  input  AW-2 (bits [AW-1:2])  first word address; sampled with START.
REQ-007 LEN  input  AW-1  word count, 0..2^(AW-1)-1; sampled with START.
REQ-008 PATTERN  input  32  fill data; sampled with START.
REQ-009 BUSY  output  1  high from the edge that samples START until the DONE cycle.
REQ-010 DONE  output  1  one-cycle completion pulse.
REQ-011 BR_ADDR  output  AW-2 (bits [AW-1:2])  word address to bram_bank ADDR.
REQ-012 BR_WDATA  output  32  write data to bram_bank WDATA.
REQ-013 BR_WREN  output  4  byte write enables to bram_bank WREN.
REQ-014 BR_RDATA  input  32  bram_bank RDATA; valid one edge after BR_ADDR is presented.
REQ-015 M_DATA  output  32  read-stream data.
REQ-016 M_VALID  output  1  M_DATA valid.
REQ-017 M_READY  input  1  downstream accept; a transfer occurs on an edge with M_VALID=1 and M_READY=1.

Function
REQ-018 States SHALL be IDLE, FILL, READ, DRAIN and FIN.
- IDLE to FILL or READ on START.
- FILL to FIN after the last write.
- READ to DRAIN after the last read is issued.
- DRAIN to FIN when the buffer is empty and nothing is in flight.
- FIN to IDLE unconditionally.
REQ-019 START with LEN=0 SHALL go IDLE to FIN: no BRAM write, no M_VALID, DONE on the next cycle.
REQ-020 Word i (i = 0..LEN-1) SHALL use address (BASE+i) mod D; wrap-around is silent, and LEN > D revisits words.
REQ-021 FILL: in the cycle after the START edge and each following cycle, BR_WREN=4'hF, BR_WDATA=PATTERN, BR_ADDR=word i; exactly LEN consecutive write cycles.
REQ-022 BR_WREN SHALL be 4'h0 in every state except FILL; BR_WDATA SHALL be 0 outside FILL.
REQ-023 READ issue: a word issues in a cycle in which (buffer occupancy + in-flight count) < 2, and BR_ADDR then carries that word's address.
REQ-024 BR_RDATA for an issued word SHALL be captured into a 2-entry FIFO on the next edge.
REQ-025 M_DATA/M_VALID SHALL present the FIFO head.
REQ-026 With M_READY held at 1, READ SHALL sustain 1 word per cycle; the first M_VALID rises 2 edges after the START edge.
REQ-027 While M_VALID=1 and M_READY=0, M_DATA SHALL be held stable; no word is lost, duplicated or reordered.
REQ-028 A FIFO push and pop on the same edge SHALL keep occupancy unchanged.
REQ-029 DONE SHALL pulse in FIN only:
- FILL: the cycle after the last write cycle.
- READ: the cycle after the last word is accepted.
REQ-030 BUSY SHALL fall in the cycle following DONE.
REQ-031 START while BUSY=1 SHALL be ignored without any side effect.
REQ-032 BR_ADDR SHALL hold its last value while not issuing; reads of this address are discarded.

Reset
REQ-033 On RESETn=0, all of the following SHALL be cleared immediately and asynchronously: state to IDLE, counters, FIFO, in-flight flags, BUSY, DONE, M_VALID, M_DATA, BR_WREN, BR_WDATA, BR_ADDR = 0.
REQ-034 Reset during FILL or READ SHALL abort the operation:
- no DONE;
- BRAM words already written stay written.
After RESETn rises, the next START SHALL be accepted normally.

Verification
REQ-035 Fill, AW=6, BASE=2, LEN=3, PATTERN=32'hA5A5_0001 -> BR_WREN=F at addresses 2,3,4 on 3 consecutive cycles; DONE one cycle later; read-back through bram_bank returns the pattern.
REQ-036 Read, BASE=0, LEN=4, M_READY=1, bank preloaded 0x11,0x22,0x33,0x44 -> M_DATA 0x11..0x44 on 4 consecutive cycles; first M_VALID 2 edges after START; DONE the cycle after the 4th transfer.
REQ-037 Read, LEN=8, M_READY pattern 1,0,0,1,0,1,1,0 repeating -> all 8 words in order, none duplicated; M_DATA stable during every stall.
REQ-038 Wrap, AW=6, BASE=14, LEN=4, read -> BR_ADDR sequence 14,15,0,1; stream data matches those words.
REQ-039 LEN=0 (either MODE) -> DONE on the next cycle; BR_WREN never nonzero; M_VALID never high. START repeated while BUSY -> ignored.
REQ-040 RESETn low after 2 of 6 read words are accepted -> M_VALID, BUSY, BR_WREN = 0 within the reset cycle; no DONE; a new START (BASE=5, LEN=2) after release completes normally.

Source files
------------

// File: rtl/bram_stream_ctrl.sv
// rtl/bram_stream_ctrl.sv - BRAM fill / read-stream controller with 2-entry output FIFO
//
// Fills a run of BRAM words with a constant pattern, or streams a run of
// words out through a valid/ready port. Word addresses wrap modulo the
// bank depth D = 2^(AW-2).
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   start, mode          command strobe (accepted only when idle); 0 = read, 1 = fill
//   base, len, pattern   first word address, word count, fill data
//   busy, done           command in progress; one-cycle completion pulse
//   br_addr, br_wdata,   bank address, write data, byte write enables
//   br_wren, br_rdata    and registered read data (valid one edge after br_addr)
//   m_data, m_valid,     read-stream output, FIFO head
//   m_ready
module bram_stream_ctrl #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-3:0] base,
    input  logic [AW-2:0] len,
    input  logic [31:0]   pattern,
    output logic          busy,
    output logic          done,
    output logic [AW-3:0] br_addr,
    output logic [31:0]   br_wdata,
    output logic [3:0]    br_wren,
    input  logic [31:0]   br_rdata,
    output logic [31:0]   m_data,
    output logic          m_valid,
    input  logic          m_ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    localparam logic [AW-2:0] LEN_ONE  = {{(AW-2){1'b0}}, 1'b1};
    localparam logic [AW-3:0] ADDR_ONE = {{(AW-3){1'b0}}, 1'b1};

    state_t        state;
    state_t        state_n;
    logic [AW-2:0] remain;      // words still to write / issue
    logic [AW-3:0] addr_q;      // address of the next word to write / issue
    logic [31:0]   pat_q;
    logic          inflight;    // a read was issued last cycle; br_rdata holds it now
    logic [31:0]   fifo_mem [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    occ;

    logic          pop;
    logic          push;
    logic [1:0]    occ_after_pop;
    logic          issue;
    logic          write;
    logic          accept;

    assign pop           = (occ != 2'd0) && m_ready;
    assign push          = inflight;
    assign occ_after_pop = occ - {1'b0, pop};
    // Occupancy is counted after this cycle's pop so that a full-rate stream
    // (one entry buffered, one in flight, one leaving) keeps issuing.
    assign issue  = (state == S_READ) && ((occ_after_pop + {1'b0, inflight}) < 2'd2);
    assign write  = (state == S_FILL);
    assign accept = (state == S_IDLE) && start;

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_FIN);
    assign br_addr  = addr_q;
    assign br_wren  = write ? 4'hF : 4'h0;
    assign br_wdata = write ? pat_q : 32'h0;
    assign m_valid  = (occ != 2'd0);
    assign m_data   = fifo_mem[rd_ptr];

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0)
                        state_n = S_FIN;
                    else
                        state_n = mode ? S_FILL : S_READ;
                end
            end
            S_FILL:  if (remain == LEN_ONE) state_n = S_FIN;
            S_READ:  if (issue && remain == LEN_ONE) state_n = S_DRAIN;
            // Leave once the last buffered word is being accepted this cycle.
            S_DRAIN: if (!inflight && occ_after_pop == 2'd0) state_n = S_FIN;
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            remain      <= '0;
            addr_q      <= '0;
            pat_q       <= '0;
            inflight    <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            occ         <= 2'd0;
        end else begin
            state    <= state_n;
            inflight <= issue;
            if (accept) begin
                remain <= len;
                addr_q <= base;
                pat_q  <= pattern;
            end else if (issue || write) begin
                remain <= remain - LEN_ONE;
                // Keep the last word's address once the run is exhausted.
                if (remain != LEN_ONE)
                    addr_q <= addr_q + ADDR_ONE;
            end
            if (push) begin
                fifo_mem[wr_ptr] <= br_rdata;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_bram_stream_ctrl.sv
// tb/tb_bram_stream_ctrl.sv - directed self-checking bench for bram_stream_ctrl
module tb_bram_stream_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        mode;
    logic [3:0]  base;
    logic [4:0]  len;
    logic [31:0] pattern;
    logic        busy;
    logic        done;
    logic [3:0]  br_addr;
    logic [31:0] br_wdata;
    logic [3:0]  br_wren;
    logic [31:0] br_rdata;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;

    int checks   = 0;
    int failures = 0;

    logic [31:0] bank [16];
    logic        do_preload = 1'b0;

    always #5 clk = ~clk;

    bram_stream_ctrl #(.AW(6)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .mode     (mode),
        .base     (base),
        .len      (len),
        .pattern  (pattern),
        .busy     (busy),
        .done     (done),
        .br_addr  (br_addr),
        .br_wdata (br_wdata),
        .br_wren  (br_wren),
        .br_rdata (br_rdata),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
    );

    // Bank model: byte-enabled write, registered read.
    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < 16; i++)
                bank[i] <= (i + 1) * 32'h11;
        end else begin
            for (int b = 0; b < 4; b++)
                if (br_wren[b]) bank[br_addr][b*8 +: 8] <= br_wdata[b*8 +: 8];
        end
        br_rdata <= bank[br_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic preload();
        do_preload = 1'b1;
        step();
        do_preload = 1'b0;
    endtask

    task automatic issue_cmd(input logic md, input logic [3:0] b, input logic [4:0] l,
                             input logic [31:0] p);
        start   = 1'b1;
        mode    = md;
        base    = b;
        len     = l;
        pattern = p;
        step();
        start   = 1'b0;
    endtask

    initial begin
        logic [7:0]  rpat;
        logic [31:0] held;
        logic        held_v;
        logic        prev_xfer;
        logic        seen_done;
        int          k;

        resetn  = 1'b0;
        start   = 1'b0;
        mode    = 1'b0;
        base    = 4'd0;
        len     = 5'd0;
        pattern = 32'h0;
        m_ready = 1'b0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_wren", br_wren, 0);
        chk("rst_addr", br_addr, 0);
        chk("rst_wdata", br_wdata, 0);
        chk("rst_mdata", m_data, 0);
        resetn = 1'b1;
        step();

        // Fill BASE=2 LEN=3, with an ignored START mid-operation
        preload();
        issue_cmd(1'b1, 4'd2, 5'd3, 32'hA5A5_0001);
        chk("fill_c1_wren", br_wren, 4'hF);
        chk("fill_c1_addr", br_addr, 2);
        chk("fill_c1_wdata", br_wdata, 32'hA5A5_0001);
        chk("fill_c1_busy", busy, 1);
        start = 1'b1; mode = 1'b0; base = 4'd9; len = 5'd5; pattern = 32'hDEAD_BEEF;
        step();
        start = 1'b0;
        chk("fill_c2_wren", br_wren, 4'hF);
        chk("fill_c2_addr", br_addr, 3);
        chk("fill_c2_wdata", br_wdata, 32'hA5A5_0001);
        step();
        chk("fill_c3_wren", br_wren, 4'hF);
        chk("fill_c3_addr", br_addr, 4);
        chk("fill_c3_done", done, 0);
        step();
        chk("fill_c4_done", done, 1);
        chk("fill_c4_wren", br_wren, 0);
        chk("fill_c4_wdata", br_wdata, 0);
        step();
        chk("fill_c5_busy", busy, 0);
        chk("fill_c5_done", done, 0);
        chk("fill_bank2", bank[2], 32'hA5A5_0001);
        chk("fill_bank3", bank[3], 32'hA5A5_0001);
        chk("fill_bank4", bank[4], 32'hA5A5_0001);
        chk("fill_bank1", bank[1], 32'h22);
        chk("fill_bank5", bank[5], 32'h66);

        // Read BASE=0 LEN=4 at full rate
        preload();
        m_ready = 1'b1;
        issue_cmd(1'b0, 4'd0, 5'd4, 32'h0);
        chk("rd_c1_valid", m_valid, 0);
        chk("rd_c1_addr", br_addr, 0);
        chk("rd_c1_wren", br_wren, 0);
        step();
        chk("rd_c2_valid", m_valid, 0);
        chk("rd_c2_addr", br_addr, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rd_valid", m_valid, 1);
            chk("rd_data", m_data, (i + 1) * 32'h11);
            chk("rd_nodone", done, 0);
        end
        step();
        chk("rd_done", done, 1);
        chk("rd_done_valid", m_valid, 0);
        step();
        chk("rd_busy_low", busy, 0);

        // Wrap BASE=14 LEN=4
        issue_cmd(1'b0, 4'd14, 5'd4, 32'h0);
        chk("wrap_a0", br_addr, 14);
        step();
        chk("wrap_a1", br_addr, 15);
        step();
        chk("wrap_a2", br_addr, 0);
        chk("wrap_d0", m_data, 32'hFF);
        step();
        chk("wrap_a3", br_addr, 1);
        chk("wrap_d1", m_data, 32'h110);
        step();
        chk("wrap_d2", m_data, 32'h11);
        step();
        chk("wrap_d3", m_data, 32'h22);
        chk("wrap_v3", m_valid, 1);
        step();
        chk("wrap_done", done, 1);
        step();

        // Read LEN=8 with ready pattern 1,0,0,1,0,1,1,0
        rpat      = 8'h69;
        k         = 0;
        held      = 32'h0;
        held_v    = 1'b0;
        prev_xfer = 1'b0;
        seen_done = 1'b0;
        m_ready   = rpat[0];
        issue_cmd(1'b0, 4'd0, 5'd8, 32'h0);
        for (int t = 1; t < 80 && !seen_done; t++) begin
            m_ready = rpat[t % 8];
            if (held_v) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_hold", m_data, held);
            end
            if (done) begin
                seen_done = 1'b1;
                chk("stall_done_after_last", prev_xfer, 1);
            end else begin
                held_v    = m_valid && !m_ready;
                held      = m_data;
                prev_xfer = m_valid && m_ready;
                if (m_valid && m_ready) begin
                    chk("stall_data", m_data, (k + 1) * 32'h11);
                    k++;
                end
                step();
            end
        end
        chk("stall_count", k, 8);
        chk("stall_seen_done", seen_done, 1);
        step();
        m_ready = 1'b1;

        // LEN=0 in both modes, START repeated while busy
        for (int md = 0; md < 2; md++) begin
            issue_cmd(md[0], 4'd3, 5'd0, 32'hFFFF_FFFF);
            chk("len0_done", done, 1);
            chk("len0_busy", busy, 1);
            chk("len0_wren", br_wren, 0);
            chk("len0_valid", m_valid, 0);
            start = 1'b1; mode = 1'b1; base = 4'd0; len = 5'd3;
            step();
            start = 1'b0;
            chk("len0_ign_busy", busy, 0);
            chk("len0_ign_done", done, 0);
            chk("len0_ign_wren", br_wren, 0);
            step();
            chk("len0_ign_busy2", busy, 0);
            chk("len0_ign_valid", m_valid, 0);
        end

        // Reset after two of six words accepted, then a fresh read
        issue_cmd(1'b0, 4'd0, 5'd6, 32'h0);
        step();
        step();
        chk("abort_w0", m_data, 32'h11);
        step();
        chk("abort_w1", m_data, 32'h22);
        step();
        chk("abort_w2_valid", m_valid, 1);
        resetn = 1'b0;
        #1;
        chk("abort_valid", m_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_wren", br_wren, 0);
        chk("abort_addr", br_addr, 0);
        chk("abort_mdata", m_data, 0);
        chk("abort_done", done, 0);
        step();
        step();
        chk("abort_done2", done, 0);
        resetn = 1'b1;
        step();
        chk("abort_done3", done, 0);
        chk("abort_busy3", busy, 0);
        issue_cmd(1'b0, 4'd5, 5'd2, 32'h0);
        chk("post_c1_addr", br_addr, 5);
        step();
        step();
        chk("post_d0_valid", m_valid, 1);
        chk("post_d0", m_data, 32'h66);
        step();
        chk("post_d1", m_data, 32'h77);
        step();
        chk("post_done", done, 1);
        step();
        chk("post_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
